// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
interface mc_control_fsm_if #(
  parameter int unsigned RETIRE_W = 16
);
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_en;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_src;
  logic [3:0]          state;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  // Control FSM side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal,
           retired
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, state, illegal,
           retired
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with illegal-opcode detection and a
// retired-instruction counter. Control outputs decode state/mem_ready/zero
// combinationally so the datapath sees them in the same cycle.
module mc_control_fsm #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire_inc;

  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;

  // State and retired-count registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    retire_inc = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          state_d    = S_FETCH;
          retire_inc = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = bus.zero;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retire_inc ? retired_q + RETIRE_W'(1) : retired_q;
  end

  // Drive the bundle
  assign bus.pc_en      = pc_en;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: an instruction-level model expands each
// instruction into its per-cycle expected controls; a negedge monitor compares.
module tb_mc_control_fsm;

  // Narrow counter so the wrap-around is reachable in a short run
  localparam int unsigned RW = 8;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                 MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9,
                 ADDIWB = 10, JUMP = 11;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

  typedef struct {
    logic [3:0]    st;
    logic [15:0]   ctl;
    logic [RW-1:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.RETIRE_W(RW)) bus();
  mc_control_fsm #(.RETIRE_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t          sbq[$];
  int            n_pass = 0;
  int            n_total = 0;
  logic [RW-1:0] ret_m;
  logic [15:0]   act_ctl;

  assign act_ctl = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                    bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal};

  // Control table per state, straight from the state descriptions
  function automatic logic [15:0] ctl_of(int st, logic mr, logic z, logic ill);
    logic pe, io, mrd, mwr, irw, rd, m2r, rw, asa;
    logic [1:0] asb, aop, ps;
    {pe, io, mrd, mwr, irw, rd, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pe = mr; end
      DECODE: asb = 2'b11;
      MEMADR: begin asa = 1'b1; asb = 2'b10; end
      MEMRD:  begin io = 1'b1; mrd = 1'b1; end
      MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      MEMWR:  begin io = 1'b1; mwr = 1'b1; end
      EXEC:   begin asa = 1'b1; aop = 2'b10; end
      ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      BRANCH: begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pe = z; end
      ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      ADDIWB: rw = 1'b1;
      JUMP:   begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, ps, ill};
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  // Drive one cycle of inputs and queue the expected response for it
  task automatic cyc(int st, logic mr, logic z, logic [5:0] op, logic ill);
    exp_t e;
    bus.mem_ready = mr;
    bus.zero      = z;
    bus.opcode    = op;
    e.st  = 4'(st);
    e.ctl = ctl_of(st, mr, z, ill);
    e.ret = ret_m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  // Expand one instruction into its cycle sequence
  task automatic run_instr(logic [5:0] op, int fw, int mw, logic z);
    for (int i = 0; i < fw; i++) cyc(FETCH, 1'b0, rb(), rop(), 1'b0);
    cyc(FETCH, 1'b1, rb(), rop(), 1'b0);
    cyc(DECODE, rb(), rb(), op, !is_legal(op));
    if (!is_legal(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      cyc(MEMADR, rb(), rb(), op, 1'b0);
      if (op == OP_LW) begin
        for (int i = 0; i < mw; i++) cyc(MEMRD, 1'b0, rb(), rop(), 1'b0);
        cyc(MEMRD, 1'b1, rb(), rop(), 1'b0);
        cyc(MEMWB, rb(), rb(), rop(), 1'b0);
      end else begin
        for (int i = 0; i < mw; i++) cyc(MEMWR, 1'b0, rb(), rop(), 1'b0);
        cyc(MEMWR, 1'b1, rb(), rop(), 1'b0);
      end
    end else if (op == OP_R) begin
      cyc(EXEC, rb(), rb(), rop(), 1'b0);
      cyc(ALUWB, rb(), rb(), rop(), 1'b0);
    end else if (op == OP_BEQ) begin
      cyc(BRANCH, rb(), z, rop(), 1'b0);
    end else if (op == OP_ADDI) begin
      cyc(ADDIEX, rb(), rb(), rop(), 1'b0);
      cyc(ADDIWB, rb(), rb(), rop(), 1'b0);
    end else begin
      cyc(JUMP, rb(), rb(), rop(), 1'b0);
    end
    ret_m = ret_m + RW'(1);
  endtask

  // Start a lw/sw, stall in its memory state, then pull reset between edges
  task automatic abort_in(logic [5:0] op);
    exp_t e;
    cyc(FETCH, 1'b1, rb(), rop(), 1'b0);
    cyc(DECODE, rb(), rb(), op, 1'b0);
    cyc(MEMADR, rb(), rb(), op, 1'b0);
    bus.mem_ready = 1'b0;
    e.st  = (op == OP_LW) ? 4'(MEMRD) : 4'(MEMWR);
    e.ctl = ctl_of(int'(e.st), 1'b0, bus.zero, 1'b0);
    e.ret = ret_m;
    sbq.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_retired", 32'(bus.retired), 32'd0);
    chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
    chk("abort_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_state", 32'(bus.state), 32'd0);
    reset = 1'b1;
    ret_m = '0;
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_total++;
      if (bus.state === e.st && act_ctl === e.ctl && bus.retired === e.ret) n_pass++;
      else $display("FAIL cycle_check: got state=%0d ctl=%h retired=%0d, required state=%0d ctl=%h retired=%0d",
                    bus.state, act_ctl, bus.retired, e.st, e.ctl, e.ret);
    end
  end

  initial begin
    logic [5:0] op;
    logic [5:0] ops [6];
    int         k;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

    reset = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    ret_m = '0;

    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'h3f;
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_retired", 32'(bus.retired), 32'd0);
    chk("reset_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_state", 32'(bus.state), 32'd0);
    reset = 1'b1;

    // Directed instructions
    run_instr(OP_LW, 0, 0, 1'b0);
    chk("lw_retired", 32'(bus.retired), 32'd1);
    run_instr(OP_SW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_R, 1, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(OP_J, 2, 0, 1'b0);
    run_instr(6'h3f, 0, 0, 1'b0);
    chk("illegal_no_retire", 32'(bus.retired), 32'(ret_m));

    abort_in(OP_LW);
    abort_in(OP_SW);

    // Randomized instruction mix including illegal opcodes
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 6);
      if (k == 6) begin
        op = rop();
        if (is_legal(op)) op = 6'h3f;
      end else begin
        op = ops[k];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

    // Drive the counter to all-ones with jumps, then one more must wrap it
    for (int n = 0; n < (1 << RW) + 4; n++) begin
      if (ret_m == '1) break;
      run_instr(OP_J, 0, 0, 1'b0);
    end
    chk("preload_all_ones", 32'(bus.retired), 32'((1 << RW) - 1));
    run_instr(OP_J, 0, 0, 1'b0);
    chk("wrap_retired", 32'(bus.retired), 32'd0);

    for (int n = 0; n < 5 && sbq.size() > 0; n++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d queued entries, required 0", sbq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: RETIRE_W, 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, independent of clk.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access-complete handshake.
REQ-007 pc_en  output  1  PC register load enable.
REQ-008 iord  output  1  memory address select; 0 = PC, 1 = ALUOut.
REQ-009 mem_read, mem_write  output  1 each  memory strobes.
REQ-010 ir_write  output  1  instruction register load.
REQ-011 reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath mux selects and register-file write enable.
REQ-012 alu_src_b  output  2  ALU B select; 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-013 alu_op  output  2  to the ALU control unit; 00 = add, 01 = sub, 10 = funct field.
REQ-014 pc_src  output  2  next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 state  output  4  current state encoding.
REQ-016 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-017 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-018 States shall be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 shall return to FETCH on the next edge.
REQ-019 Any output not listed for a state shall be 0.
REQ-020 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_en=mem_ready; the FSM shall hold in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; the next state shall be chosen by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXEC; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
REQ-022 For any other opcode in DECODE, illegal shall be 1 for that cycle and the next state shall be FETCH; retired shall not increment.
REQ-023 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: iord=1, mem_read=1; hold while mem_ready=0, then go to MEMWB.
REQ-025 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-026 MEMWR: iord=1, mem_write=1; hold while mem_ready=0, then go to FETCH.
REQ-027 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-028 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; next state FETCH.
REQ-030 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
REQ-031 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-032 JUMP: pc_src=10, pc_en=1; next state FETCH.
REQ-033 opcode shall be sampled only in DECODE and MEMADR; changes to opcode in other states shall have no effect.
REQ-034 retired shall increment by 1 on each edge that leaves MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP for FETCH, and shall wrap from all-ones to 0.
REQ-035 Outputs shall be combinational decodes of state, mem_ready and zero, with no extra latency; state and retired shall be registered.
REQ-036 Cycle counts with mem_ready tied to 1 shall be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-037 While reset=0: state=FETCH, retired=0, illegal=0.
REQ-038 Reset asserted mid-instruction shall abandon the instruction; a write in progress shall not complete and retired shall not increment.
REQ-039 The first rising clk edge after reset deasserts shall evaluate the FETCH transition.

Verification
REQ-040 lw with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4; retired 0->1.
REQ-041 sw with mem_ready low for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, then FETCH; retired +1.
REQ-042 beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH; with zero=0 -> pc_en=0; both cases return to FETCH.
REQ-043 opcode 111111 -> illegal pulses for 1 cycle in DECODE, then FETCH; retired unchanged.
REQ-044 reset=0 asserted asynchronously during MEMRD -> state=0 and retired=0 immediately, before the next clk edge.
REQ-045 Preload retired to 16'hFFFF via consecutive j instructions, then complete one more j -> retired=0.
